// File: rtl/wordcount_dma_sequencer.sv
// Job sequencer for the wordcount datapath: splits a host job into chunk-sized
// read/write transfer pairs and reports busy/done/error back to the host.
module wordcount_dma_sequencer #(
    parameter int unsigned CHUNK_WORDS         = 64,
    parameter logic [63:0] RESULT_OFFSET       = 64'h0000_0000_1000_0000,
    parameter int unsigned BYTES_PER_WORD_LOG2 = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        kick,
    input  logic [31:0] command,
    input  logic [31:0] num_of_words,
    input  logic [63:0] global_memory_offset,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [31:0] chunk_count,
    input  logic        beat_fire,
    output logic        reader_ctrl_start,
    input  logic        reader_ctrl_done,
    output logic [63:0] reader_ctrl_addr_offset,
    output logic [63:0] reader_ctrl_xfer_size_in_bytes,
    output logic        writer_ctrl_start,
    input  logic        writer_ctrl_done,
    output logic [63:0] writer_ctrl_addr_offset,
    output logic [63:0] writer_ctrl_xfer_size_in_bytes
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_ISSUE = 3'd1,
        RD_WAIT  = 3'd2,
        WR_ISSUE = 3'd3,
        WR_WAIT  = 3'd4,
        FINISH   = 3'd5
    } state_t;

    localparam logic [31:0] CMD_NOP     = 32'd0;
    localparam logic [31:0] CMD_RUN     = 32'd1;
    localparam logic [31:0] CHUNK_LEN   = 32'(CHUNK_WORDS);
    localparam logic [63:0] CHUNK_BYTES = 64'(CHUNK_WORDS) << BYTES_PER_WORD_LOG2;

    function automatic logic [31:0] clip_len(input logic [31:0] words);
        return (words > CHUNK_LEN) ? CHUNK_LEN : words;
    endfunction

    function automatic logic [63:0] len_bytes(input logic [31:0] words);
        return {32'd0, words} << BYTES_PER_WORD_LOG2;
    endfunction

    // state is kept as a named signal so checkers can bind to it directly
    state_t      state;
    state_t      state_next;
    logic [31:0] remaining;
    logic [31:0] cur;
    logic [31:0] beat_cnt;
    logic [31:0] rem_after;
    logic [31:0] next_cur;
    logic [31:0] final_beats;
    logic        last_chunk;
    logic        start_run;
    logic        illegal_cmd;

    assign rem_after   = remaining - cur;
    assign next_cur    = clip_len(rem_after);
    assign last_chunk  = (rem_after == 32'd0);
    assign final_beats = beat_cnt + {31'd0, beat_fire};
    assign start_run   = (command == CMD_RUN) && (num_of_words != 32'd0);
    assign illegal_cmd = (command != CMD_NOP) && (command != CMD_RUN);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next        = state;
        busy              = 1'b1;
        done              = 1'b0;
        reader_ctrl_start = 1'b0;
        writer_ctrl_start = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (kick) begin
                    state_next = start_run ? RD_ISSUE : FINISH;
                end
            end
            RD_ISSUE: begin
                reader_ctrl_start = 1'b1;
                state_next        = RD_WAIT;
            end
            RD_WAIT: begin
                if (reader_ctrl_done) begin
                    state_next = WR_ISSUE;
                end
            end
            WR_ISSUE: begin
                writer_ctrl_start = 1'b1;
                state_next        = WR_WAIT;
            end
            WR_WAIT: begin
                if (writer_ctrl_done) begin
                    state_next = last_chunk ? FINISH : RD_ISSUE;
                end
            end
            FINISH: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                busy       = 1'b0;
                state_next = IDLE;
            end
        endcase
    end

    // Transfer descriptors are loaded on the edge that enters the ISSUE state,
    // so they are valid alongside the start pulse and held until the next one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            remaining                      <= 32'd0;
            cur                            <= 32'd0;
            beat_cnt                       <= 32'd0;
            error                          <= 1'b0;
            chunk_count                    <= 32'd0;
            reader_ctrl_addr_offset        <= 64'd0;
            reader_ctrl_xfer_size_in_bytes <= 64'd0;
            writer_ctrl_addr_offset        <= 64'd0;
            writer_ctrl_xfer_size_in_bytes <= 64'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (kick) begin
                        remaining   <= num_of_words;
                        cur         <= clip_len(num_of_words);
                        error       <= illegal_cmd;
                        chunk_count <= 32'd0;
                        if (start_run) begin
                            reader_ctrl_addr_offset        <= global_memory_offset;
                            reader_ctrl_xfer_size_in_bytes <= len_bytes(clip_len(num_of_words));
                        end
                    end
                end
                RD_ISSUE: begin
                    beat_cnt <= 32'd0;
                end
                RD_WAIT: begin
                    if (beat_fire) begin
                        beat_cnt <= final_beats;
                    end
                    if (reader_ctrl_done) begin
                        // a short or long stream is flagged but the chunk still completes
                        if (final_beats != cur) begin
                            error <= 1'b1;
                        end
                        writer_ctrl_addr_offset        <= reader_ctrl_addr_offset + RESULT_OFFSET;
                        writer_ctrl_xfer_size_in_bytes <= reader_ctrl_xfer_size_in_bytes;
                    end
                end
                WR_WAIT: begin
                    if (writer_ctrl_done) begin
                        chunk_count <= chunk_count + 32'd1;
                        remaining   <= rem_after;
                        if (!last_chunk) begin
                            cur                            <= next_cur;
                            reader_ctrl_addr_offset        <= reader_ctrl_addr_offset + CHUNK_BYTES;
                            reader_ctrl_xfer_size_in_bytes <= len_bytes(next_cur);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wordcount_dma_sequencer.sv
// Self-checking bench for wordcount_dma_sequencer: directed jobs plus random
// jobs, with reader/writer responders and a chunk-list reference model.
module tb_wordcount_dma_sequencer;

    localparam logic [63:0] CW   = 64'd64;
    localparam logic [63:0] ROFF = 64'h0000_0000_1000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        kick;
    logic [31:0] command;
    logic [31:0] num_of_words;
    logic [63:0] global_memory_offset;
    logic        busy;
    logic        done;
    logic        error;
    logic [31:0] chunk_count;
    logic        beat_fire;
    logic        reader_ctrl_start;
    logic        reader_ctrl_done;
    logic [63:0] reader_ctrl_addr_offset;
    logic [63:0] reader_ctrl_xfer_size_in_bytes;
    logic        writer_ctrl_start;
    logic        writer_ctrl_done;
    logic [63:0] writer_ctrl_addr_offset;
    logic [63:0] writer_ctrl_xfer_size_in_bytes;

    int total = 0;
    int bad   = 0;

    logic [63:0] exp_rd_q[$];
    logic [63:0] exp_wr_q[$];
    logic [63:0] exp_sz_q[$];
    logic [63:0] last_rd_addr = 64'd0;
    logic [63:0] last_wr_addr = 64'd0;
    logic [63:0] last_sz      = 64'd0;

    wordcount_dma_sequencer dut (
        .clk                            (clk),
        .reset                          (reset),
        .kick                           (kick),
        .command                        (command),
        .num_of_words                   (num_of_words),
        .global_memory_offset           (global_memory_offset),
        .busy                           (busy),
        .done                           (done),
        .error                          (error),
        .chunk_count                    (chunk_count),
        .beat_fire                      (beat_fire),
        .reader_ctrl_start              (reader_ctrl_start),
        .reader_ctrl_done               (reader_ctrl_done),
        .reader_ctrl_addr_offset        (reader_ctrl_addr_offset),
        .reader_ctrl_xfer_size_in_bytes (reader_ctrl_xfer_size_in_bytes),
        .writer_ctrl_start              (writer_ctrl_start),
        .writer_ctrl_done               (writer_ctrl_done),
        .writer_ctrl_addr_offset        (writer_ctrl_addr_offset),
        .writer_ctrl_xfer_size_in_bytes (writer_ctrl_xfer_size_in_bytes)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // reference model: job -> list of (read addr, write addr, size) per chunk
    function automatic int build_expect(input logic [31:0] cmd, input logic [31:0] nw,
                                        input logic [63:0] base);
        logic [63:0] nwl;
        logic [63:0] nch;
        logic [63:0] words;
        exp_rd_q.delete();
        exp_wr_q.delete();
        exp_sz_q.delete();
        if (cmd != 32'd1) return 0;
        nwl = {32'd0, nw};
        nch = (nwl + CW - 64'd1) / CW;
        for (logic [63:0] k = 0; k < nch; k++) begin
            words = (k == nch - 64'd1) ? (nwl - k * CW) : CW;
            exp_rd_q.push_back(base + k * CW * 64'd64);
            exp_wr_q.push_back(base + ROFF + k * CW * 64'd64);
            exp_sz_q.push_back(words * 64'd64);
        end
        return int'(nch);
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_err"}, error, 0);
        check({tag, "_chunks"}, chunk_count, 0);
        check({tag, "_rd_start"}, reader_ctrl_start, 0);
        check({tag, "_wr_start"}, writer_ctrl_start, 0);
        check({tag, "_rd_addr"}, reader_ctrl_addr_offset, 0);
        check({tag, "_rd_size"}, reader_ctrl_xfer_size_in_bytes, 0);
        check({tag, "_wr_addr"}, writer_ctrl_addr_offset, 0);
        check({tag, "_wr_size"}, writer_ctrl_xfer_size_in_bytes, 0);
    endtask

    task automatic kick_job(input logic [31:0] cmd, input logic [31:0] nw, input logic [63:0] base);
        command              = cmd;
        num_of_words         = nw;
        global_memory_offset = base;
        kick                 = 1'b1;
        @(negedge clk);
        kick = 1'b0;
    endtask

    task automatic do_abort();
        int seen;
        #2 reset = 1'b1;
        #1 check_all_zero("abort");
        @(negedge clk);
        reset = 1'b0;
        seen  = 0;
        repeat (3) begin
            @(negedge clk);
            seen = seen | int'(done) | int'(busy);
        end
        check("abort_quiet", seen, 0);
        last_rd_addr = 64'd0;
        last_wr_addr = 64'd0;
        last_sz      = 64'd0;
    endtask

    // driver: kicks a job and plays reader/writer, checking each handshake
    task automatic run_job(input logic [31:0] cmd, input logic [31:0] nw, input logic [63:0] base,
                           input int short_chunk, input int bad_pct, input bit noise,
                           input int abort_chunk);
        int          nch;
        int          nbeats;
        int          b;
        bit          exp_err;
        bit          sent;
        logic [63:0] rd_a;
        logic [63:0] wr_a;
        logic [63:0] sz;
        nch     = build_expect(cmd, nw, base);
        exp_err = (cmd > 32'd1);
        kick_job(cmd, nw, base);
        if (nch == 0) begin
            check("empty_done", done, 1);
            check("empty_busy", busy, 1);
            check("empty_rd_start", reader_ctrl_start, 0);
            check("empty_err", error, exp_err);
            check("empty_chunks", chunk_count, 0);
            check("hold_rd_addr", reader_ctrl_addr_offset, last_rd_addr);
            check("hold_wr_addr", writer_ctrl_addr_offset, last_wr_addr);
            check("hold_wr_size", writer_ctrl_xfer_size_in_bytes, last_sz);
            @(negedge clk);
            check("empty_end_done", done, 0);
            check("empty_end_busy", busy, 0);
            return;
        end
        for (int k = 0; k < nch; k++) begin
            rd_a = exp_rd_q.pop_front();
            wr_a = exp_wr_q.pop_front();
            sz   = exp_sz_q.pop_front();
            check("rd_start", reader_ctrl_start, 1);
            check("rd_addr", reader_ctrl_addr_offset, rd_a);
            check("rd_size", reader_ctrl_xfer_size_in_bytes, sz);
            check("mid_done", done, 0);
            check("mid_busy", busy, 1);
            if (noise) begin
                beat_fire        = 1'b1;
                reader_ctrl_done = 1'b1;
                writer_ctrl_done = 1'b1;
            end
            @(negedge clk);
            beat_fire        = 1'b0;
            reader_ctrl_done = 1'b0;
            writer_ctrl_done = 1'b0;
            nbeats = int'(sz >> 6);
            if (k == short_chunk) nbeats--;
            else if ($urandom_range(0, 99) < bad_pct)
                nbeats = ($urandom_range(0, 1) == 1) ? nbeats + 1 : nbeats - 1;
            if (nbeats != int'(sz >> 6)) exp_err = 1'b1;
            b    = nbeats;
            sent = 1'b0;
            while (b > 0) begin
                beat_fire = ($urandom_range(0, 3) != 0);
                if (beat_fire) b--;
                reader_ctrl_done = (b == 0) && beat_fire && ($urandom_range(0, 1) == 1);
                sent = reader_ctrl_done;
                kick = noise && ($urandom_range(0, 1) == 1);
                if (noise) begin
                    command      = 32'd1;
                    num_of_words = $urandom_range(1, 500);
                end
                @(negedge clk);
            end
            beat_fire        = 1'b0;
            kick             = 1'b0;
            if (!sent) begin
                reader_ctrl_done = 1'b1;
                @(negedge clk);
            end
            reader_ctrl_done = 1'b0;
            check("wr_start", writer_ctrl_start, 1);
            check("wr_addr", writer_ctrl_addr_offset, wr_a);
            check("wr_size", writer_ctrl_xfer_size_in_bytes, sz);
            check("wr_rd_start_low", reader_ctrl_start, 0);
            if (noise) begin
                writer_ctrl_done = 1'b1;
                reader_ctrl_done = 1'b1;
                beat_fire        = 1'b1;
            end
            @(negedge clk);
            writer_ctrl_done = 1'b0;
            reader_ctrl_done = 1'b0;
            beat_fire        = 1'b0;
            if (k == abort_chunk) begin
                do_abort();
                return;
            end
            repeat ($urandom_range(0, 3)) begin
                reader_ctrl_done = noise;
                @(negedge clk);
            end
            reader_ctrl_done = 1'b0;
            check("wr_wait_start_low", writer_ctrl_start, 0);
            writer_ctrl_done = 1'b1;
            @(negedge clk);
            writer_ctrl_done = 1'b0;
            last_rd_addr = rd_a;
            last_wr_addr = wr_a;
            last_sz      = sz;
        end
        check("fin_done", done, 1);
        check("fin_busy", busy, 1);
        check("fin_chunks", chunk_count, nch);
        check("fin_err", error, exp_err);
        check("fin_rd_start", reader_ctrl_start, 0);
        @(negedge clk);
        check("end_done", done, 0);
        check("end_busy", busy, 0);
        check("end_chunks", chunk_count, nch);
    endtask

    // main sequence and final report
    initial begin
        logic [31:0] cmd;
        int          r;
        reset                = 1'b1;
        kick                 = 1'b0;
        command              = 32'd0;
        num_of_words         = 32'd0;
        global_memory_offset = 64'd0;
        beat_fire            = 1'b0;
        reader_ctrl_done     = 1'b0;
        writer_ctrl_done     = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;
        @(negedge clk);

        run_job(32'd1, 32'd128, 64'h8000_0000, -1, 0, 1'b0, -1);
        run_job(32'd1, 32'd100, 64'h8000_0000, -1, 0, 1'b0, -1);
        run_job(32'd1, 32'd0, 64'h1234_0000, -1, 0, 1'b0, -1);
        run_job(32'd0, 32'd5, 64'h1234_0000, -1, 0, 1'b0, -1);
        run_job(32'd2, 32'd5, 64'h1234_0000, -1, 0, 1'b0, -1);
        run_job(32'd1, 32'd64, 64'h4000_0000, 0, 0, 1'b0, -1);
        run_job(32'd1, 32'd1, 64'h4000_0040, -1, 0, 1'b0, -1);
        run_job(32'd1, 32'd130, 64'h8000_0000, -1, 0, 1'b1, -1);
        run_job(32'd1, 32'd128, 64'h8000_0000, -1, 0, 1'b0, 1);
        run_job(32'd1, 32'd128, 64'h8000_0000, -1, 0, 1'b0, -1);
        run_job(32'd1, 32'd200, 64'hFFFF_FFFF_FFFF_F000, -1, 0, 1'b0, -1);

        repeat (25) begin
            r   = $urandom_range(0, 99);
            cmd = (r < 85) ? 32'd1 : ((r < 93) ? 32'd0 : $urandom);
            run_job(cmd, $urandom_range(0, 300), {$urandom, $urandom}, -1, 10,
                    ($urandom_range(0, 1) == 1), -1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
